// File: rtl/uart_frame_sched.sv
// Round-robin scheduler sharing one framed UART transmitter among N_REQ sources.
// Optional WAIT watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_frame_sched #(
  parameter int N_REQ          = 4,
  parameter int FRAME_BYTES    = 16,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*FRAME_BYTES*8-1:0] data_in,
  output logic [N_REQ-1:0]               ack,
  output logic                           tx_st,
  output logic [FRAME_BYTES*8-1:0]       tx_data,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           err_timeout,
  output logic [7:0]                     err_cnt
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  if (N_REQ < 2 || N_REQ > 8 || FRAME_BYTES < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
      $error("uart_frame_sched: parameter out of range");
    end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t          state_q;
  logic [N_REQ-1:0] ack_q;
  logic            tx_st_q;
  logic [FW-1:0]   tx_data_q;
  logic            busy_q;
  logic [IW-1:0]   grant_id_q;
  logic [GW-1:0]   gap_cnt_q;

  logic            pick_vld_d;
  logic [IW-1:0]   pick_id_d;
  logic [IW-1:0]   scan_idx;

  // Scan from the farthest candidate down to grant_id+1 so the nearest set request wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_id_d  = grant_id_q;
    scan_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = IW'((int'(grant_id_q) + k) % N_REQ);
      if (req[scan_idx]) begin
        pick_vld_d = 1'b1;
        pick_id_d  = scan_idx;
      end
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          err_timeout_q;
  logic [7:0]    err_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      tx_st_q    <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= LAST_ID;
      gap_cnt_q  <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_cnt_q     <= '0;
`endif
    end else begin
      ack_q   <= '0;
      tx_st_q <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (en && pick_vld_d) begin
            tx_data_q  <= data_in[int'(pick_id_d)*FW +: FW];
            grant_id_q <= pick_id_d;
            tx_st_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
`ifdef UART_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (tx_done) begin
            ack_q <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end
`ifdef UART_SCHED_TIMEOUT_EN
          // Expiry abandons the frame without ack; grant_id already points past it.
          else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
`endif
        end
        S_GAP: begin
          if (gap_cnt_q <= GW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign tx_st    = tx_st_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

`ifdef UART_SCHED_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
  assign err_cnt     = err_cnt_q;
`else
  assign err_timeout = 1'b0;
  assign err_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched: vector table of frames plus hand-written corner cases.
module tb_uart_frame_sched;
  localparam int N   = 4;
  localparam int FB  = 16;
  localparam int FW  = FB * 8;
  localparam int GAP = 4;
  localparam int TMO = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*FW-1:0]   data_in;
  logic [N-1:0]      ack;
  logic              tx_st;
  logic [FW-1:0]     tx_data;
  logic              tx_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err_timeout;
  logic [7:0]        err_cnt;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] exp_ack_q[$];

  uart_frame_sched #(
    .N_REQ(N), .FRAME_BYTES(FB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_in(data_in),
    .ack(ack), .tx_st(tx_st), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] frame(input int i);
    logic [7:0] b;
    if (i == 0) return 128'h00112233445566778899AABBCCDDEEFF;
    b = 8'hA0 + 8'(i);
    return {16{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts in IDLE; grants, completes one frame and returns in IDLE.
  task automatic run_frame(input logic [N-1:0] r, input logic [1:0] exp, input int dly,
                           input logic gap_done, input logic hold);
    int n;
    logic [N-1:0] e;
    req = r;
    n = 0;
    while (tx_st !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tx_st_seen", FW'(tx_st), 1);
    check("grant_latency", FW'(n), 1);
    check("grant_id", FW'(grant_id), FW'(exp));
    check("tx_data", tx_data, frame(int'(exp)));
    check("busy_start", FW'(busy), 1);
    exp_ack_q.push_back(4'b0001 << exp);
    data_in[int'(exp)*FW +: FW] = ~frame(int'(exp));
    tick();
    if (hold) en = 1'b0;
    check("tx_st_pulse", FW'(tx_st), 0);
    check("tx_data_held", tx_data, frame(int'(exp)));
    data_in[int'(exp)*FW +: FW] = frame(int'(exp));
    repeat (dly - 1) tick();
    check("ack_before_done", FW'(ack), 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    e = exp_ack_q.pop_front();
    check("ack", FW'(ack), FW'(e));
    if (!hold) req = '0;
    if (gap_done) tx_done = 1'b1;
    n = 1;
    tick();
    tx_done = 1'b0;
    check("ack_single", FW'(ack), 0);
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check("gap_len", FW'(n), FW'(GAP));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   exp_gid;
    int           dly;
    logic         gap_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b0001, 2'd0, 50, 1'b0};
    vecs[1] = '{4'b1111, 2'd1, 50, 1'b0};
    vecs[2] = '{4'b1111, 2'd2, 50, 1'b1};
    vecs[3] = '{4'b1111, 2'd3, 50, 1'b0};
    vecs[4] = '{4'b1111, 2'd0, 50, 1'b0};
    vecs[5] = '{4'b1010, 2'd1, 3,  1'b0};
    vecs[6] = '{4'b1010, 2'd3, 3,  1'b1};
    vecs[7] = '{4'b0110, 2'd1, 2,  1'b0};
    vecs[8] = '{4'b0100, 2'd2, 1,  1'b0};
    vecs[9] = '{4'b1001, 2'd3, 5,  1'b0};

    for (int i = 0; i < N; i++) data_in[i*FW +: FW] = frame(i);

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_ack", FW'(ack), 0);
    check("rst_tx_st", FW'(tx_st), 0);
    check("rst_busy", FW'(busy), 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", FW'(grant_id), 3);
    check("rst_err_timeout", FW'(err_timeout), 0);
    check("rst_err_cnt", FW'(err_cnt), 0);
    #3 rst_n = 1'b1;
    tick();
    en = 1'b1;

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].req, vecs[i].exp_gid, vecs[i].dly, vecs[i].gap_done, 1'b0);

    // tx_done while idle is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("idle_done_ack", FW'(ack), 0);
    check("idle_done_busy", FW'(busy), 0);
    tick();
    check("idle_done_busy2", FW'(busy), 0);

    // en dropped during WAIT: frame completes, then pending req waits for en
    run_frame(4'b0100, 2'd2, 5, 1'b0, 1'b1);
    repeat (10) tick();
    check("en_low_busy", FW'(busy), 0);
    check("en_low_tx_st", FW'(tx_st), 0);
    en = 1'b1;
    run_frame(4'b0100, 2'd2, 5, 1'b0, 1'b0);

    // reset in WAIT aborts without ack and restores priority to source 0
    req = 4'b0010;
    tick();
    check("pre_rst_tx_st", FW'(tx_st), 1);
    check("pre_rst_gid", FW'(grant_id), 1);
    req = '0;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", FW'(busy), 0);
    check("mid_rst_gid", FW'(grant_id), 3);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_tx_st", FW'(tx_st), 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ack", FW'(ack), 0);
    run_frame(4'b1111, 2'd0, 3, 1'b0, 1'b0);

`ifdef UART_SCHED_TIMEOUT_EN
    req = 4'b0001;
    tick();
    check("tmo_tx_st", FW'(tx_st), 1);
    check("tmo_gid", FW'(grant_id), 0);
    req = '0;
    repeat (TMO) tick();
    check("tmo_early", FW'(err_timeout), 0);
    tick();
    check("tmo_pulse", FW'(err_timeout), 1);
    check("tmo_cnt", FW'(err_cnt), 1);
    check("tmo_no_ack", FW'(ack), 0);
    check("tmo_busy_gap", FW'(busy), 1);
    tick();
    check("tmo_single", FW'(err_timeout), 0);
    repeat (GAP + 2) tick();
    check("tmo_idle", FW'(busy), 0);
`else
    check("no_tmo_err", FW'(err_timeout), 0);
    check("no_tmo_cnt", FW'(err_cnt), 0);
`endif

    check("sb_empty", FW'(exp_ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
